sram_bank_ctrl: RTL and testbench
=================================

SRAM_BANK_CTRL -- requirements
Module: sram_bank_ctrl

Interface
REQ-001 SHALL have parameter BANK_AW, default 10: word-address bits per SRAM bank.
REQ-002 SHALL have parameter BANK_SEL_W, default 6: bank-select bits; NB = 2**BANK_SEL_W banks.
REQ-003 SHALL have parameter DW, default 8: data width.
REQ-004 SHALL have parameter RD_LAT, default 1, legal range 1..15: macro read latency in cycles.
REQ-005 SHALL have port CLK input 1: clock, all logic on rising edge.
REQ-006 SHALL have port RSTN input 1: reset, asynchronous, active-low.
REQ-007 SHALL have port REQ_VALID input 1: request present.
REQ-008 SHALL have port REQ_READY output 1: request accepted when REQ_VALID && REQ_READY at a rising edge.
REQ-009 SHALL have port REQ_WE input 1: 1 = write, 0 = read.
REQ-010 SHALL have port REQ_ADDR input BANK_SEL_W+BANK_AW: {bank, word} address.
REQ-011 SHALL have port REQ_WDATA input DW: write data.
REQ-012 SHALL have port REQ_LEN input 4: read burst length minus 1.
REQ-013 SHALL have port RSP_VALID output 1: read data valid, one-cycle pulse per beat, no backpressure.
REQ-014 SHALL have port RSP_RDATA output DW: read data.
REQ-015 SHALL have port RSP_LAST output 1: final beat of a read, qualified by RSP_VALID.
REQ-016 SHALL have ports MEM_ADDR output BANK_AW, MEM_CE output 1, MEM_WEB output 1, MEM_IDATA output DW: shared macro bus.
REQ-017 SHALL have ports MEM_CSB output NB and MEM_OEB output NB: per-bank active-low selects.
REQ-018 SHALL have port MEM_ODATA input NB*DW: concatenated bank outputs; bank b occupies bits [b*DW +: DW].

Function
REQ-019 SHALL implement states IDLE, ACCESS, RDWAIT; REQ_READY SHALL be 1 only in IDLE.
REQ-020 On acceptance, SHALL register address, WE, WDATA and length, then enter ACCESS on the next cycle.
REQ-021 In ACCESS, SHALL drive MEM_CE=1, MEM_ADDR=word, MEM_CSB=all ones except bit[bank]=0, and MEM_IDATA=registered data.
REQ-022 In write ACCESS, SHALL drive MEM_WEB=0, keep MEM_OEB all ones, then return to IDLE; a write SHALL occupy exactly one ACCESS cycle, and REQ_LEN SHALL be ignored for writes.
REQ-023 In read ACCESS, SHALL drive MEM_WEB=1 and MEM_OEB bit[bank]=0, then stay in RDWAIT for RD_LAT cycles with MEM_CSB/MEM_OEB held and MEM_CE=0.
REQ-024 At the last RDWAIT edge, SHALL capture MEM_ODATA slice [bank] into RSP_RDATA and assert RSP_VALID in the following cycle.
REQ-025 Accept-to-RSP_VALID latency SHALL be RD_LAT+2 cycles; burst beats SHALL be spaced RD_LAT+1 cycles apart.
REQ-026 Outside ACCESS/RDWAIT, SHALL hold MEM_CSB and MEM_OEB all ones, MEM_CE=0 and MEM_WEB=1.
REQ-027 Burst address SHALL increment by 1 per beat across the full BANK_SEL_W+BANK_AW space; crossing a bank boundary SHALL move the select to the next bank, and the top address SHALL wrap to 0.
REQ-028 After the final beat's capture, SHALL return to IDLE; REQ_READY SHALL rise in the same cycle as the final RSP_VALID.
REQ-029 RSP_RDATA SHALL hold its last value between pulses.

Reset
REQ-030 While RSTN=0, SHALL hold state IDLE, REQ_READY=1, RSP_VALID=0, RSP_LAST=0, RSP_RDATA=0, MEM_ADDR=0, MEM_CE=0, MEM_WEB=1, MEM_IDATA=0, and MEM_CSB and MEM_OEB all ones.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately and emit no further RSP_VALID.

Configuration
REQ-032 With SRAM_BANK_CTRL_BURST_EN defined, reads SHALL return REQ_LEN+1 beats per REQ-027; without it, REQ_LEN SHALL be ignored, every read SHALL be single-beat, and RSP_LAST SHALL equal RSP_VALID.

Verification
REQ-033 Reset: RSTN low mid-read -> all outputs at REQ-030 values asynchronously; no RSP_VALID after release.
REQ-034 Write: 0x0403 with data 0xA5, defaults -> one cycle with MEM_CE=1, MEM_WEB=0, MEM_ADDR=0x003, MEM_CSB=~(1<<1); MEM_OEB all ones.
REQ-035 Read: 0xFC10, bank 63, MEM_ODATA slice 63 = 0x5A, RD_LAT=1 -> RSP_VALID=1, RSP_RDATA=0x5A, RSP_LAST=1, 3 cycles after acceptance.
REQ-036 Burst, macro defined: read 0x03FE with LEN=3 -> 4 beats at addresses 0x03FE, 0x03FF, 0x0400, 0x0401; CSB moves from bank 0 to bank 1; RSP_LAST on beat 4.
REQ-037 Wrap, macro defined: read 0xFFFF with LEN=1 -> second beat at address 0x0000 from bank 0.
REQ-038 Backpressure/macro off: REQ_VALID held during a read -> REQ_READY=0 until the final RSP_VALID; with the macro off, LEN=3 yields exactly one beat.

Source files
------------

// File: rtl/sram_bank_ctrl.sv
// Banked SRAM access controller: a shared macro bus, per-bank active-low selects, and read data captured after RD_LAT cycles.
// Define SRAM_BANK_CTRL_BURST_EN for multi-beat reads (REQ_LEN+1 beats); without it every read is a single beat.
module sram_bank_ctrl #(
   parameter int BANK_AW    = 10,
   parameter int BANK_SEL_W = 6,
   parameter int DW         = 8,
   parameter int RD_LAT     = 1
) (
   input  logic                          CLK,
   input  logic                          RSTN,
   input  logic                          REQ_VALID,
   output logic                          REQ_READY,
   input  logic                          REQ_WE,
   input  logic [BANK_SEL_W+BANK_AW-1:0] REQ_ADDR,
   input  logic [DW-1:0]                 REQ_WDATA,
   input  logic [3:0]                    REQ_LEN,
   output logic                          RSP_VALID,
   output logic [DW-1:0]                 RSP_RDATA,
   output logic                          RSP_LAST,
   output logic [BANK_AW-1:0]            MEM_ADDR,
   output logic                          MEM_CE,
   output logic                          MEM_WEB,
   output logic [DW-1:0]                 MEM_IDATA,
   output logic [(2**BANK_SEL_W)-1:0]    MEM_CSB,
   output logic [(2**BANK_SEL_W)-1:0]    MEM_OEB,
   input  logic [(2**BANK_SEL_W)*DW-1:0] MEM_ODATA
);

   // state  | meaning
   // IDLE   | ready for a request, macro bus parked
   // ACCESS | one macro strobe cycle (write, or launch of a read beat)
   // RDWAIT | bank held selected/output-enabled for RD_LAT cycles
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDWAIT = 2'd2
   } state_t;

   localparam int AW = BANK_SEL_W + BANK_AW;
   localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

   state_t                state_q, state_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic                  we_q, we_d;
   logic [DW-1:0]         wdata_q, wdata_d;
   logic [3:0]            len_q, len_d;
   logic [3:0]            wait_q, wait_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_last_q, rsp_last_d;
   logic [DW-1:0]         rdata_q, rdata_d;
   logic [BANK_SEL_W-1:0] bank;

   assign bank      = addr_q[AW-1:BANK_AW];
   assign MEM_ADDR  = addr_q[BANK_AW-1:0];
   assign MEM_IDATA = wdata_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_LAST  = rsp_last_q;
   assign RSP_RDATA = rdata_q;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         len_q       <= '0;
         wait_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         len_q       <= len_d;
         wait_q      <= wait_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_last_q  <= rsp_last_d;
         rdata_q     <= rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      len_d       = len_q;
      wait_d      = wait_q;
      rsp_valid_d = 1'b0;
      rsp_last_d  = 1'b0;
      rdata_d     = rdata_q;
      REQ_READY   = 1'b0;
      MEM_CE      = 1'b0;
      MEM_WEB     = 1'b1;
      MEM_CSB     = '1;
      MEM_OEB     = '1;
      case (state_q)
         IDLE: begin
            REQ_READY = 1'b1;
            if (REQ_VALID) begin
               addr_d  = REQ_ADDR;
               we_d    = REQ_WE;
               wdata_d = REQ_WDATA;
`ifdef SRAM_BANK_CTRL_BURST_EN
               len_d   = REQ_LEN;
`else
               // single-beat build: the length field is deliberately discarded
               len_d   = REQ_LEN & 4'h0;
`endif
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            MEM_CE        = 1'b1;
            MEM_CSB[bank] = 1'b0;
            if (we_q) begin
               MEM_WEB = 1'b0;
               state_d = IDLE;
            end else begin
               MEM_OEB[bank] = 1'b0;
               wait_d        = WAIT_INIT;
               state_d       = RDWAIT;
            end
         end
         RDWAIT: begin
            MEM_CSB[bank] = 1'b0;
            MEM_OEB[bank] = 1'b0;
            if (wait_q == 4'd0) begin
               rdata_d     = MEM_ODATA[bank*DW +: DW];
               rsp_valid_d = 1'b1;
               rsp_last_d  = (len_q == 4'd0);
               if (len_q == 4'd0) begin
                  state_d = IDLE;
               end else begin
                  // full-width increment: carries into the bank field and wraps at the top
                  len_d   = len_q - 4'd1;
                  addr_d  = addr_q + 1'b1;
                  state_d = ACCESS;
               end
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Randomized self-checking bench for sram_bank_ctrl; a static random SRAM image serves as the reference memory.
module tb_sram_bank_ctrl;

   localparam int BANK_AW    = 10;
   localparam int BANK_SEL_W = 6;
   localparam int DW         = 8;
   localparam int RD_LAT     = 1;
   localparam int AW         = BANK_SEL_W + BANK_AW;
   localparam int NB         = 2**BANK_SEL_W;
   localparam int PER        = RD_LAT + 1;
`ifdef SRAM_BANK_CTRL_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic              CLK, RSTN;
   logic              REQ_VALID, REQ_READY, REQ_WE;
   logic [AW-1:0]     REQ_ADDR;
   logic [DW-1:0]     REQ_WDATA;
   logic [3:0]        REQ_LEN;
   logic              RSP_VALID, RSP_LAST;
   logic [DW-1:0]     RSP_RDATA;
   logic [BANK_AW-1:0] MEM_ADDR;
   logic              MEM_CE, MEM_WEB;
   logic [DW-1:0]     MEM_IDATA;
   logic [NB-1:0]     MEM_CSB, MEM_OEB;
   logic [NB*DW-1:0]  MEM_ODATA;

   logic [DW-1:0] memv [0:(2**AW)-1];
   int n_tests = 0;
   int n_fail  = 0;

   sram_bank_ctrl #(.BANK_AW(BANK_AW), .BANK_SEL_W(BANK_SEL_W), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
      .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_LEN(REQ_LEN),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_LAST(RSP_LAST),
      .MEM_ADDR(MEM_ADDR), .MEM_CE(MEM_CE), .MEM_WEB(MEM_WEB), .MEM_IDATA(MEM_IDATA),
      .MEM_CSB(MEM_CSB), .MEM_OEB(MEM_OEB), .MEM_ODATA(MEM_ODATA)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Banks only drive their slice while output-enabled; otherwise the slice reads as zero.
   always_comb begin
      MEM_ODATA = '0;
      for (int b = 0; b < NB; b++) begin
         logic [BANK_SEL_W-1:0] bs;
         bs = BANK_SEL_W'(b);
         if (!MEM_OEB[b]) MEM_ODATA[b*DW +: DW] = memv[{bs, MEM_ADDR}];
      end
   end

   task automatic check_reset_values(input string tag);
      logic [NB-1:0] ones;
      ones = '1;
      n_tests++;
      if ({REQ_READY, RSP_VALID, RSP_LAST, RSP_RDATA, MEM_ADDR, MEM_CE, MEM_WEB, MEM_IDATA}
          !== {1'b1, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b1, 8'h00}) begin
         n_fail++;
         $display("FAIL %s scalars: got rdy=%b v=%b l=%b rd=%h a=%h ce=%b web=%b id=%h", tag,
                  REQ_READY, RSP_VALID, RSP_LAST, RSP_RDATA, MEM_ADDR, MEM_CE, MEM_WEB, MEM_IDATA);
      end
      n_tests++;
      if (MEM_CSB !== ones || MEM_OEB !== ones) begin
         n_fail++;
         $display("FAIL %s selects: got csb=%h oeb=%h want all ones", tag, MEM_CSB, MEM_OEB);
      end
   endtask

   // Present a request (aligned #1 after a rising edge) and let it be accepted on the next edge.
   task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] len, input bit hold);
      REQ_VALID = 1'b1;
      REQ_WE    = we;
      REQ_ADDR  = a;
      REQ_WDATA = d;
      REQ_LEN   = len;
      n_tests++;
      if (REQ_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_idle: got %b want 1", REQ_READY);
      end
      @(posedge CLK); #1;
      if (!hold) REQ_VALID = 1'b0;
   endtask

   task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] len);
      logic [NB-1:0] oh, ones;
      ones = '1;
      oh   = '0;
      oh[a[AW-1:BANK_AW]] = 1'b1;
      issue(1'b1, a, d, len, 1'b0);
      n_tests++;
      if ({MEM_CE, MEM_WEB, MEM_ADDR, MEM_IDATA, REQ_READY} !== {1'b1, 1'b0, a[BANK_AW-1:0], d, 1'b0}
          || MEM_CSB !== ~oh || MEM_OEB !== ones) begin
         n_fail++;
         $display("FAIL write_access a=%h: got ce=%b web=%b addr=%h id=%h rdy=%b csb=%h oeb=%h want addr=%h id=%h csb=%h",
                  a, MEM_CE, MEM_WEB, MEM_ADDR, MEM_IDATA, REQ_READY, MEM_CSB, MEM_OEB, a[BANK_AW-1:0], d, ~oh);
      end
      for (int k = 2; k <= 3; k++) begin
         @(posedge CLK); #1;
         n_tests++;
         if ({MEM_CE, MEM_WEB, REQ_READY, RSP_VALID} !== 4'b0110 || MEM_CSB !== ones || MEM_OEB !== ones) begin
            n_fail++;
            $display("FAIL write_idle k=%0d: got ce=%b web=%b rdy=%b v=%b csb=%h oeb=%h", k,
                     MEM_CE, MEM_WEB, REQ_READY, RSP_VALID, MEM_CSB, MEM_OEB);
         end
      end
   endtask

   task automatic run_read(input logic [AW-1:0] a, input logic [3:0] len, input bit hold, input string tag);
      int beats, total, j, bidx, ph;
      bit exp_v, have;
      logic [AW-1:0] ea;
      logic [DW-1:0] last_data;
      logic [NB-1:0] oh, ones;
      ones  = '1;
      beats = BURST ? int'(len) + 1 : 1;
      total = beats * PER + 1;
      have  = 1'b0;
      last_data = '0;
      issue(1'b0, a, DW'($urandom), len, hold);
      for (int k = 1; k <= total; k++) begin
         exp_v = (k >= PER + 1) && (((k - 1) % PER) == 0);
         n_tests++;
         if (RSP_VALID !== exp_v) begin
            n_fail++;
            $display("FAIL %s rsp_valid k=%0d: got %b want %b", tag, k, RSP_VALID, exp_v);
         end
         if (exp_v) begin
            j  = (k - 1) / PER - 1;
            ea = a + AW'(j);
            last_data = memv[ea];
            have = 1'b1;
            n_tests++;
            if (RSP_RDATA !== memv[ea] || RSP_LAST !== (j == beats - 1)) begin
               n_fail++;
               $display("FAIL %s beat%0d @%h: got data=%h last=%b want data=%h last=%b", tag, j, ea,
                        RSP_RDATA, RSP_LAST, memv[ea], (j == beats - 1));
            end
         end else if (have) begin
            n_tests++;
            if (RSP_RDATA !== last_data) begin
               n_fail++;
               $display("FAIL %s rdata_hold k=%0d: got %h want %h", tag, k, RSP_RDATA, last_data);
            end
         end
         if (k <= beats * PER) begin
            bidx = (k - 1) / PER;
            ph   = (k - 1) % PER;
            ea   = a + AW'(bidx);
            oh   = '0;
            oh[ea[AW-1:BANK_AW]] = 1'b1;
            n_tests++;
            if ({MEM_CE, MEM_WEB, REQ_READY} !== {(ph == 0), 1'b1, 1'b0} || MEM_ADDR !== ea[BANK_AW-1:0]
                || MEM_CSB !== ~oh || MEM_OEB !== ~oh) begin
               n_fail++;
               $display("FAIL %s bus k=%0d @%h: got ce=%b web=%b rdy=%b addr=%h csb=%h oeb=%h want ce=%b addr=%h sel=%h",
                        tag, k, ea, MEM_CE, MEM_WEB, REQ_READY, MEM_ADDR, MEM_CSB, MEM_OEB,
                        (ph == 0), ea[BANK_AW-1:0], ~oh);
            end
         end else begin
            n_tests++;
            if ({MEM_CE, REQ_READY} !== 2'b01 || MEM_CSB !== ones || MEM_OEB !== ones) begin
               n_fail++;
               $display("FAIL %s end k=%0d: got ce=%b rdy=%b csb=%h oeb=%h want ce=0 rdy=1 parked",
                        tag, k, MEM_CE, REQ_READY, MEM_CSB, MEM_OEB);
            end
            REQ_VALID = 1'b0;
         end
         @(posedge CLK); #1;
      end
      for (int k = 0; k < 2 * PER; k++) begin
         n_tests++;
         if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL %s drain k=%0d: got v=%b rdy=%b want v=0 rdy=1", tag, k, RSP_VALID, REQ_READY);
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_reset();
      RSTN = 1'b0;
      #7;
      check_reset_values("reset_init");
      @(posedge CLK); #1;
      check_reset_values("reset_held");
      RSTN = 1'b1;
      @(posedge CLK); #1;
      check_reset_values("reset_release");
   endtask

   task automatic test_write();
      run_write(16'h0403, 8'hA5, 4'(3));
      for (int i = 0; i < 4; i++) run_write(AW'($urandom), DW'($urandom), 4'($urandom));
   endtask

   task automatic test_read();
      memv[16'hFC10] = 8'h5A;
      run_read(16'hFC10, 4'd0, 1'b0, "read_fc10");
   endtask

   task automatic test_burst();
      run_read(16'h03FE, 4'd3, 1'b0, "burst_bank_cross");
   endtask

   task automatic test_wrap();
      run_read(16'hFFFF, 4'd1, 1'b0, "wrap");
   endtask

   task automatic test_back_to_back();
      run_read(AW'($urandom), 4'd3, 1'b1, "backpressure");
      run_read(AW'($urandom), 4'd2, 1'b1, "backpressure2");
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(0, 1) == 1) run_write(AW'($urandom), DW'($urandom), 4'($urandom));
         else run_read(AW'($urandom), 4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), "random_read");
      end
   endtask

   task automatic test_reset_midread();
      issue(1'b0, 16'h13FF, 8'h00, 4'd3, 1'b0);
      #2;
      RSTN = 1'b0;
      #1;
      check_reset_values("reset_async");
      @(posedge CLK); #1;
      check_reset_values("reset_async_held");
      #2;
      RSTN = 1'b1;
      for (int k = 0; k < 6 * PER + 2; k++) begin
         @(posedge CLK); #1;
         n_tests++;
         if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1 || MEM_CE !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset k=%0d: got v=%b rdy=%b ce=%b want 0 1 0", k, RSP_VALID, REQ_READY, MEM_CE);
         end
      end
   endtask

   initial begin
      RSTN      = 1'b0;
      REQ_VALID = 1'b0;
      REQ_WE    = 1'b0;
      REQ_ADDR  = '0;
      REQ_WDATA = '0;
      REQ_LEN   = '0;
      for (int i = 0; i < 2**AW; i++) memv[i] = DW'($urandom);
      test_reset();
      test_write();
      test_read();
      test_burst();
      test_wrap();
      test_back_to_back();
      test_random();
      test_reset_midread();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
